// File: rtl/game_pkg.sv
// Shared state encoding, BCD limits and start defaults for the game timer.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX            = 4'd9;
    localparam logic [3:0] DEFAULT_START_TENS = 4'd6;
    localparam logic [3:0] DEFAULT_START_ONES = 4'd0;

    function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_down2.sv
// Two-digit BCD decrementer. Flags 00 and 01; decrementing 00 saturates at 00.
module bcd_down2 (
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic [3:0] dec_tens,
    output logic [3:0] dec_ones,
    output logic       zero,
    output logic       last
);
    import game_pkg::*;

    always_comb begin
        dec_tens = tens;
        dec_ones = ones;
        if (ones != 4'd0) begin
            dec_ones = ones - 4'd1;
        end else if (tens != 4'd0) begin
            dec_tens = tens - 4'd1;
            dec_ones = BCD_MAX;
        end
    end

    assign zero = (tens == 4'd0) && (ones == 4'd0);
    assign last = (tens == 4'd0) && (ones == 4'd1);

endmodule

// File: rtl/game_timer.sv
// Seconds countdown: divides upstream ticks to seconds and counts a BCD pair down to 00.
module game_timer #(
    parameter int unsigned TICKS_PER_SEC = 10,
    parameter logic [3:0]  START_TENS    = game_pkg::DEFAULT_START_TENS,
    parameter logic [3:0]  START_ONES    = game_pkg::DEFAULT_START_ONES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       pause,
    input  logic       load_en,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       expired,
    output logic       done_pulse
);
    import game_pkg::*;

    localparam logic [7:0] SUB_LAST = 8'(TICKS_PER_SEC - 1);

    state_t     state, state_n;
    logic [3:0] tens_n, ones_n, preset_tens, preset_ones, preset_tens_n, preset_ones_n;
    logic [7:0] sub_cnt, sub_cnt_n;
    logic       done_n;
    logic [3:0] dec_tens, dec_ones, lt_c, lo_c;
    logic       zero, last;

    bcd_down2 u_dec (
        .tens     (tens),
        .ones     (ones),
        .dec_tens (dec_tens),
        .dec_ones (dec_ones),
        .zero     (zero),
        .last     (last)
    );

    assign lt_c = clamp_bcd(load_tens);
    assign lo_c = clamp_bcd(load_ones);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tens        <= START_TENS;
            ones        <= START_ONES;
            preset_tens <= START_TENS;
            preset_ones <= START_ONES;
            sub_cnt     <= '0;
            done_pulse  <= 1'b0;
        end else begin
            state       <= state_n;
            tens        <= tens_n;
            ones        <= ones_n;
            preset_tens <= preset_tens_n;
            preset_ones <= preset_ones_n;
            sub_cnt     <= sub_cnt_n;
            done_pulse  <= done_n;
        end
    end

    always_comb begin
        state_n       = state;
        tens_n        = tens;
        ones_n        = ones;
        preset_tens_n = preset_tens;
        preset_ones_n = preset_ones;
        sub_cnt_n     = sub_cnt;
        done_n        = 1'b0;
        unique case (state)
            IDLE: begin
                if (load_en) begin
                    preset_tens_n = lt_c;
                    preset_ones_n = lo_c;
                    tens_n        = lt_c;
                    ones_n        = lo_c;
                    sub_cnt_n     = '0;
                end else if (start && !zero) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (tick) begin
                    if (sub_cnt == SUB_LAST) begin
                        sub_cnt_n = '0;
                        tens_n    = dec_tens;
                        ones_n    = dec_ones;
                        if (last) begin
                            state_n = EXPIRED;
                            done_n  = 1'b1;
                        end
                    end else begin
                        sub_cnt_n = sub_cnt + 8'd1;
                    end
                end
                // A tick landing on 00 takes priority over a simultaneous pause.
                if (pause && state_n != EXPIRED) begin
                    state_n = PAUSED;
                end
            end
            PAUSED: begin
                if (load_en) begin
                    preset_tens_n = lt_c;
                    preset_ones_n = lo_c;
                    tens_n        = lt_c;
                    ones_n        = lo_c;
                    sub_cnt_n     = '0;
                    state_n       = IDLE;
                end else if (start) begin
                    state_n = RUN;
                end
            end
            EXPIRED: begin
                if (load_en) begin
                    preset_tens_n = lt_c;
                    preset_ones_n = lo_c;
                    tens_n        = lt_c;
                    ones_n        = lo_c;
                    sub_cnt_n     = '0;
                    state_n       = IDLE;
                end else if (start) begin
                    tens_n    = preset_tens;
                    ones_n    = preset_ones;
                    sub_cnt_n = '0;
                    state_n   = (preset_tens == 4'd0 && preset_ones == 4'd0) ? IDLE : RUN;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign running = (state == RUN);
    assign expired = (state == EXPIRED);

endmodule

// File: tb/tb_game_timer.sv
// Scoreboard bench for game_timer with two ticks per second.
module tb_game_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       load_en = 1'b0;
    logic [3:0] load_tens = '0;
    logic [3:0] load_ones = '0;
    logic [3:0] tens, ones;
    logic       running, expired, done_pulse;

    int n_checks = 0;
    int n_errors = 0;
    int step_no  = 0;

    typedef struct {
        int         n;
        logic [3:0] t;
        logic [3:0] o;
        logic       r;
        logic       x;
        logic       d;
    } exp_t;

    exp_t sb[$];

    game_timer #(
        .TICKS_PER_SEC (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .start      (start),
        .pause      (pause),
        .load_en    (load_en),
        .load_tens  (load_tens),
        .load_ones  (load_ones),
        .tens       (tens),
        .ones       (ones),
        .running    (running),
        .expired    (expired),
        .done_pulse (done_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus; the expected outputs after that edge join the scoreboard.
    task automatic cyc(input logic rs, input logic tk, input logic st, input logic pz,
                       input logic ld, input logic [3:0] lt, input logic [3:0] lo,
                       input logic [3:0] et, input logic [3:0] eo,
                       input logic er, input logic ex, input logic ed);
        exp_t e;
        rst = rs; tick = tk; start = st; pause = pz; load_en = ld;
        load_tens = lt; load_ones = lo;
        @(posedge clk);
        step_no++;
        e.n = step_no; e.t = et; e.o = eo; e.r = er; e.x = ex; e.d = ed;
        sb.push_back(e);
        #1;
        rst = 1'b0; tick = 1'b0; start = 1'b0; pause = 1'b0; load_en = 1'b0;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("s%0d.tens", e.n), 8'(tens), 8'(e.t));
            check($sformatf("s%0d.ones", e.n), 8'(ones), 8'(e.o));
            check($sformatf("s%0d.running", e.n), 8'(running), 8'(e.r));
            check($sformatf("s%0d.expired", e.n), 8'(expired), 8'(e.x));
            check($sformatf("s%0d.done", e.n), 8'(done_pulse), 8'(e.d));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        //  rst tk st pz ld  lt     lo      tens   ones  r  x  d
        // reset values
        cyc(1, 0, 0, 0, 0, 4'd0, 4'd0,  4'd6, 4'd0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 4'd0, 4'd0,  4'd6, 4'd0, 0, 0, 0);
        // 03 down to 00
        cyc(0, 0, 0, 0, 1, 4'd0, 4'd3,  4'd0, 4'd3, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 4'd0, 4'd0,  4'd0, 4'd3, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 4'd0, 4'd0,  4'd0, 4'd3, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 4'd0, 4'd0,  4'd0, 4'd2, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 4'd0, 4'd0,  4'd0, 4'd2, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 4'd0, 4'd0,  4'd0, 4'd1, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 4'd0, 4'd0,  4'd0, 4'd1, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 4'd0, 4'd0,  4'd0, 4'd0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 4'd0, 4'd0,  4'd0, 4'd0, 0, 1, 0);
        // borrow 10 -> 09, pause holds, resume
        cyc(0, 0, 0, 0, 1, 4'd1, 4'd0,  4'd1, 4'd0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 4'd0, 4'd0,  4'd1, 4'd0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 4'd0, 4'd0,  4'd1, 4'd0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 4'd0, 4'd0,  4'd0, 4'd9, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 4'd0, 4'd0,  4'd0, 4'd9, 0, 0, 0);
        for (int unsigned i = 0; i < 5; i++)
            cyc(0, 1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 4'd9, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 4'd0, 4'd0,  4'd0, 4'd9, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 4'd0, 4'd0,  4'd0, 4'd9, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 4'd0, 4'd0,  4'd0, 4'd8, 1, 0, 0);
        // load ignored in RUN; clamp on load from PAUSED; start at 00 ignored
        cyc(0, 0, 0, 0, 1, 4'd1, 4'd1,  4'd0, 4'd8, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 4'd0, 4'd0,  4'd0, 4'd8, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 4'hF, 4'hC,  4'd9, 4'd9, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 4'd0, 4'd0,  4'd0, 4'd0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 4'd0, 4'd0,  4'd0, 4'd0, 0, 0, 0);
        // load and start together in IDLE: load wins
        cyc(0, 0, 1, 0, 1, 4'd0, 4'd2,  4'd0, 4'd2, 0, 0, 0);
        // tick+pause mid-second, then tick+pause on the tick reaching 00
        cyc(0, 0, 1, 0, 0, 4'd0, 4'd0,  4'd0, 4'd2, 1, 0, 0);
        cyc(0, 1, 0, 1, 0, 4'd0, 4'd0,  4'd0, 4'd2, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 4'd0, 4'd0,  4'd0, 4'd2, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 4'd0, 4'd0,  4'd0, 4'd1, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 4'd0, 4'd0,  4'd0, 4'd1, 1, 0, 0);
        cyc(0, 1, 0, 1, 0, 4'd0, 4'd0,  4'd0, 4'd0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 4'd0, 4'd0,  4'd0, 4'd0, 0, 1, 0);
        // EXPIRED: load+start loads; run 03 out; restart from preset
        cyc(0, 0, 1, 0, 1, 4'd0, 4'd3,  4'd0, 4'd3, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 4'd0, 4'd0,  4'd0, 4'd3, 1, 0, 0);
        for (int unsigned i = 1; i <= 6; i++)
            cyc(0, 1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 4'(3 - i / 2),
                (i != 6), (i == 6), (i == 6));
        cyc(0, 0, 1, 0, 0, 4'd0, 4'd0,  4'd0, 4'd3, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 4'd0, 4'd0,  4'd0, 4'd3, 1, 0, 0);
        // reset mid-count restores 60 and the preset, sub-counter cleared
        cyc(1, 1, 0, 0, 0, 4'd0, 4'd0,  4'd6, 4'd0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 4'd0, 4'd0,  4'd6, 4'd0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 4'd0, 4'd0,  4'd6, 4'd0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 4'd0, 4'd0,  4'd5, 4'd9, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 4'd0, 4'd0,  4'd5, 4'd9, 0, 0, 0);

        for (int unsigned i = 0; i < 4 && sb.size() > 0; i++)
            @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/game_timer.md
Name: game_timer

Overview:
- Seconds countdown timer that sits directly downstream of the 0-to-100 tick counter.
- Consumes that counter's one-cycle timeout pulse as its `tick` input.
- Divides the ticks down to whole seconds and counts a two-digit BCD value down to 00.
- Drives the display digits and the game-over pulse for the game FSM.

Parameters:
- TICKS_PER_SEC, default 10: number of `tick` pulses per one-second decrement. Legal range 1..255.
- START_TENS, default 4'd6: BCD tens digit loaded at reset.
- START_ONES, default 4'd0: BCD ones digit loaded at reset.

Ports:
- clk  input  1  system clock. All logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- tick  input  1  one-cycle pulse from the upstream tick counter.
- start  input  1  one-cycle pulse: begin, resume or restart.
- pause  input  1  one-cycle pulse: pause while running.
- load_en  input  1  one-cycle pulse: load a new preset.
- load_tens  input  4  BCD tens digit for the preset.
- load_ones  input  4  BCD ones digit for the preset.
- tens  output  4  current BCD tens digit.
- ones  output  4  current BCD ones digit.
- running  output  1  high while in RUN.
- expired  output  1  high while in EXPIRED.
- done_pulse  output  1  one-cycle pulse on reaching 00.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high. All outputs are registered.
- Reset values:
  - tens = START_TENS, ones = START_ONES; the preset register gets the same values.
  - sub-counter = 0, state = IDLE.
  - running = 0, expired = 0, done_pulse = 0.
- States: IDLE, RUN, PAUSED, EXPIRED.
- IDLE:
  - load_en: preset and digits take load_tens/load_ones; sub-counter = 0.
  - start with digits != 00 -> RUN.
  - start with digits == 00 is ignored.
  - load_en and start in the same cycle: load wins, start is ignored.
- RUN:
  - Each tick increments the sub-counter.
  - A tick with sub-counter == TICKS_PER_SEC-1 sets the sub-counter to 0 and decrements the digits by one second.
  - Decrement rules: ones != 0 -> ones-1. ones == 0 -> ones = 9 and tens-1.
  - Decrement from 01 to 00: next state EXPIRED, done_pulse = 1 for exactly one cycle.
  - pause -> PAUSED. The sub-counter and digits are retained.
  - tick and pause in the same cycle: the tick is processed first, then PAUSED.
  - If that tick reaches 00, EXPIRED wins over PAUSED.
  - load_en and start are ignored in RUN.
- PAUSED:
  - tick is ignored; start -> RUN.
  - load_en: load the preset and digits, clear the sub-counter, go to IDLE.
  - pause is ignored.
- EXPIRED:
  - Digits hold 00 and expired = 1.
  - start: reload digits from the preset, clear the sub-counter, go to RUN. If the preset is 00, go to IDLE instead.
  - load_en: load the preset and digits, go to IDLE.
  - load_en and start in the same cycle: load wins.
- BCD rule: any loaded digit > 9 is clamped to 9. The digits are never outside 0..9.
- Latency: a digit change is visible on the outputs the cycle after the qualifying tick. done_pulse rises in the same cycle the digits show 00.
- Output definitions: running = (state == RUN); expired = (state == EXPIRED).
- Width: the sub-counter is 8 bits. TICKS_PER_SEC == 1 means every tick decrements.
- Reset mid-operation: rst overrides all inputs in that cycle and restores the reset values, including the preset.

Decomposition:
- Shared package game_pkg holds:
  - the state encoding (IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2, EXPIRED = 2'd3);
  - the constant BCD_MAX = 4'd9;
  - the default START_TENS/START_ONES values.
- One natural sub-module: bcd_down2. It is a two-digit BCD decrementer with a zero flag, instantiated once for the digit path.
- The state machine and sub-counter stay in game_timer.

Test Plan:
1. rst=1 for 2 cycles, default parameters -> tens=6, ones=0, running=0, expired=0, done_pulse=0.
2. TICKS_PER_SEC=2; load 0,3; start; 6 ticks -> digits go 03 -> 02 -> 01 -> 00 after ticks 2, 4, 6. After tick 6: done_pulse high for one cycle, expired=1.
3. TICKS_PER_SEC=2; load 1,0; start; 2 ticks -> 09 (borrow). Then pause plus 5 ticks -> stays 09. Then start plus 2 ticks -> 08.
4. Load 0xF,0xC -> digits read 9,9. Load 0,0 then start -> stays IDLE, running=0.
5. In RUN, pause asserted on the tick that reaches 00 -> state EXPIRED, done_pulse=1, running=0.
6. In EXPIRED with preset 0,3: start -> digits 03, RUN. Then rst mid-count -> 60, IDLE.
